conv_pool_stream: RTL and testbench

//  Streaming 2x2/stride-2 pooling stage behind the conv1 datapath. Accepts one
//  row of NUM_PIXELS_BUF signed pixels per handshake and buffers each even row.
//  On the following odd row it emits NUM_PIXELS_POOL pooled pixels (max or average).

---
 rtl/conv_pool_stream_if.sv | 26 ++
 rtl/conv_pool_stream.sv | 107 ++++++++++
 tb/tb_conv_pool_stream.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pool_stream_if.sv
// Handshake bundle for the conv1 pooling stage: input row stream, pooled output
// stream and the per-frame pooling mode select.
interface conv_pool_stream_if #(
  parameter int OPERAND_WDTH    = 19,
  parameter int NUM_PIXELS_BUF  = 4,
  parameter int NUM_PIXELS_POOL = 2
);
  logic                                    conv_pool_mode_i;
  logic                                    conv_pool_row_vld_i;
  logic                                    conv_pool_row_rdy_o;
  logic [NUM_PIXELS_BUF*OPERAND_WDTH-1:0]  conv_pool_row_i;
  logic                                    conv_pool_out_vld_o;
  logic                                    conv_pool_out_rdy_i;
  logic [NUM_PIXELS_POOL*OPERAND_WDTH-1:0] conv_pool_out_o;
  logic                                    conv_pool_frame_end_o;

  modport master (
    output conv_pool_mode_i, conv_pool_row_vld_i, conv_pool_row_i, conv_pool_out_rdy_i,
    input  conv_pool_row_rdy_o, conv_pool_out_vld_o, conv_pool_out_o, conv_pool_frame_end_o
  );

  modport slave (
    input  conv_pool_mode_i, conv_pool_row_vld_i, conv_pool_row_i, conv_pool_out_rdy_i,
    output conv_pool_row_rdy_o, conv_pool_out_vld_o, conv_pool_out_o, conv_pool_frame_end_o
  );
endinterface

// File: rtl/conv_pool_stream.sv
// 2x2 / stride-2 streaming pool (max or average) behind conv1: buffers each even
// row and emits one pooled beat when the matching odd row arrives.
//
// state | meaning
// EVEN  | waiting for an even row; an accepted row is stored in the row buffer
// ODD   | waiting for the odd row; it is pooled with the buffer into the output register
module conv_pool_stream #(
  parameter int OPERAND_WDTH    = 19,
  parameter int NUM_PIXELS_BUF  = 4,
  parameter int NUM_PIXELS_POOL = 2,
  parameter int ROWS_PER_FRAME  = 28
) (
  input logic                conv_pool_clk,
  input logic                conv_pool_rst_b,
  conv_pool_stream_if.slave  bus
);
  localparam int OW    = OPERAND_WDTH;
  localparam int CNT_W = $clog2(ROWS_PER_FRAME);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS_PER_FRAME - 1);

  typedef enum logic {EVEN = 1'b0, ODD = 1'b1} state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                row_cnt_q;
  logic [NUM_PIXELS_BUF*OW-1:0]    buf_q;
  logic                            mode_q;
  logic [NUM_PIXELS_POOL*OW-1:0]   out_q;
  logic                            fe_q;
  logic                            vld_q;
  logic                            row_rdy;
  logic                            row_acc;
  logic [NUM_PIXELS_POOL*OW-1:0]   pooled;

  // Average: a 4-way sum needs two guard bits; dropping the two LSBs of the
  // signed sum is the floor divide, and the result always fits back in OW bits.
  function automatic logic [OW-1:0] pool4(input logic signed [OW-1:0] a0, a1, b0, b1,
                                          input logic avg);
    logic signed [OW-1:0] ma, mb;
    logic signed [OW+1:0] sum;
    ma  = (a0 > a1) ? a0 : a1;
    mb  = (b0 > b1) ? b0 : b1;
    sum = {{2{a0[OW-1]}}, a0} + {{2{a1[OW-1]}}, a1} + {{2{b0[OW-1]}}, b0} + {{2{b1[OW-1]}}, b1};
    if (avg) pool4 = sum[OW+1:2];
    else     pool4 = (ma > mb) ? ma : mb;
  endfunction

  assign row_acc = bus.conv_pool_row_vld_i && row_rdy;

  always_ff @(posedge conv_pool_clk or negedge conv_pool_rst_b) begin
    if (!conv_pool_rst_b) state_q <= EVEN;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    row_rdy = 1'b1;
    case (state_q)
      EVEN: if (row_acc) state_d = ODD;
      ODD: begin
        row_rdy = !(vld_q && !bus.conv_pool_out_rdy_i);
        if (row_acc) state_d = EVEN;
      end
      default: state_d = EVEN;
    endcase
  end

  always_comb begin
    pooled = '0;
    for (int k = 0; k < NUM_PIXELS_POOL; k++) begin
      pooled[k*OW +: OW] = pool4(buf_q[(2*k)*OW +: OW], buf_q[(2*k+1)*OW +: OW],
                                 bus.conv_pool_row_i[(2*k)*OW +: OW],
                                 bus.conv_pool_row_i[(2*k+1)*OW +: OW], mode_q);
    end
  end

  always_ff @(posedge conv_pool_clk or negedge conv_pool_rst_b) begin
    if (!conv_pool_rst_b) begin
      row_cnt_q <= '0;
      buf_q     <= '0;
      mode_q    <= 1'b0;
    end else if (row_acc) begin
      row_cnt_q <= (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + CNT_W'(1);
      if (row_cnt_q == '0) mode_q <= bus.conv_pool_mode_i;
      if (state_q == EVEN) buf_q <= bus.conv_pool_row_i;
    end
  end

  // A new odd row may load on the same edge the previous beat is consumed.
  always_ff @(posedge conv_pool_clk or negedge conv_pool_rst_b) begin
    if (!conv_pool_rst_b) begin
      out_q <= '0;
      fe_q  <= 1'b0;
      vld_q <= 1'b0;
    end else if (row_acc && state_q == ODD) begin
      out_q <= pooled;
      fe_q  <= (row_cnt_q == LAST_ROW);
      vld_q <= 1'b1;
    end else if (vld_q && bus.conv_pool_out_rdy_i) begin
      vld_q <= 1'b0;
    end
  end

  assign bus.conv_pool_row_rdy_o   = row_rdy;
  assign bus.conv_pool_out_vld_o   = vld_q;
  assign bus.conv_pool_out_o       = out_q;
  assign bus.conv_pool_frame_end_o = fe_q;
endmodule

// File: tb/tb_conv_pool_stream.sv
// Scoreboard bench for conv_pool_stream: a reference model predicts every pooled
// beat at row acceptance; a negedge monitor pops and compares consumed beats.
module tb_conv_pool_stream;
  localparam int OW   = 19;
  localparam int NPB  = 4;
  localparam int NPP  = 2;
  localparam int ROWS = 4;

  typedef struct packed {
    logic [NPP*OW-1:0] out;
    logic              fe;
  } beat_t;

  logic clk;
  logic rst_b;
  int   n_vec;
  int   n_err;
  beat_t sbq[$];

  int              m_cnt;
  logic            m_odd;
  logic            m_mode;
  logic [NPB*OW-1:0] m_buf;

  conv_pool_stream_if #(.OPERAND_WDTH(OW), .NUM_PIXELS_BUF(NPB), .NUM_PIXELS_POOL(NPP)) bus ();

  conv_pool_stream #(
    .OPERAND_WDTH(OW), .NUM_PIXELS_BUF(NPB), .NUM_PIXELS_POOL(NPP), .ROWS_PER_FRAME(ROWS)
  ) dut (
    .conv_pool_clk   (clk),
    .conv_pool_rst_b (rst_b),
    .bus             (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sx(input logic [OW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [OW-1:0] ref_pool(input int a0, a1, b0, b1, input logic avg);
    int m, s, q;
    m = a0;
    if (a1 > m) m = a1;
    if (b0 > m) m = b0;
    if (b1 > m) m = b1;
    s = a0 + a1 + b0 + b1;
    q = s / 4;
    if (s < 0 && (s % 4) != 0) q = q - 1;
    return avg ? q[OW-1:0] : m[OW-1:0];
  endfunction

  function automatic logic [NPB*OW-1:0] mk_row(input int p0, p1, p2, p3);
    logic [NPB*OW-1:0] r;
    int p[4];
    p = '{p0, p1, p2, p3};
    for (int k = 0; k < NPB; k++) r[k*OW +: OW] = p[k][OW-1:0];
    return r;
  endfunction

  task automatic model_accept(input logic [NPB*OW-1:0] row);
    beat_t b;
    if (m_cnt == 0) m_mode = bus.conv_pool_mode_i;
    if (!m_odd) begin
      m_buf = row;
    end else begin
      for (int k = 0; k < NPP; k++)
        b.out[k*OW +: OW] = ref_pool(sx(m_buf[(2*k)*OW +: OW]), sx(m_buf[(2*k+1)*OW +: OW]),
                                     sx(row[(2*k)*OW +: OW]), sx(row[(2*k+1)*OW +: OW]), m_mode);
      b.fe = (m_cnt == ROWS - 1);
      sbq.push_back(b);
    end
    m_odd = !m_odd;
    m_cnt = (m_cnt + 1) % ROWS;
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (rst_b && bus.conv_pool_out_vld_o && bus.conv_pool_out_rdy_i) begin
      if (sbq.size() == 0) begin
        chk("spurious_beat", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("out", 64'(bus.conv_pool_out_o), 64'(e.out));
        chk("frame_end", 64'(bus.conv_pool_frame_end_o), 64'(e.fe));
      end
    end
  end

  task automatic drive_row(input logic [NPB*OW-1:0] row);
    bus.conv_pool_row_vld_i = 1'b1;
    bus.conv_pool_row_i     = row;
  endtask

  task automatic wait_accept();
    bit done;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.conv_pool_row_rdy_o) begin
        model_accept(bus.conv_pool_row_i);
        done = 1;
      end
      @(posedge clk); #1;
    end
    bus.conv_pool_row_vld_i = 1'b0;
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_row(input logic [NPB*OW-1:0] row);
    drive_row(row);
    wait_accept();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 64'(sbq.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    sbq.delete();
    m_cnt = 0; m_odd = 0; m_mode = 0; m_buf = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_vld", 64'(bus.conv_pool_out_vld_o), 64'd0);
    rst_b = 1'b1;
    #1;
    chk("rst_row_rdy", 64'(bus.conv_pool_row_rdy_o), 64'd1);
  endtask

  logic [NPP*OW-1:0] held;

  initial begin
    n_vec = 0; n_err = 0;
    bus.conv_pool_mode_i = 1'b0;
    bus.conv_pool_row_vld_i = 1'b0;
    bus.conv_pool_row_i = '0;
    bus.conv_pool_out_rdy_i = 1'b1;
    rst_b = 1'b0;
    m_cnt = 0; m_odd = 0; m_mode = 0; m_buf = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", 64'(bus.conv_pool_out_o), 64'd0);
    chk("reset_fe", 64'(bus.conv_pool_frame_end_o), 64'd0);
    chk("reset_vld", 64'(bus.conv_pool_out_vld_o), 64'd0);
    rst_b = 1'b1;
    #1;
    chk("reset_rdy", 64'(bus.conv_pool_row_rdy_o), 64'd1);
    @(posedge clk); #1;

    // max, with one-cycle latency
    bus.conv_pool_mode_i = 1'b0;
    send_row(mk_row(-3, 5, 0, -1));
    send_row(mk_row(2, -7, -1, -1));
    @(negedge clk);
    chk("latency_vld", 64'(bus.conv_pool_out_vld_o), 64'd1);
    drain();

    // average with floor rounding
    do_reset();
    bus.conv_pool_mode_i = 1'b1;
    send_row(mk_row(-3, 5, 0, -1));
    send_row(mk_row(2, -7, -1, -1));
    send_row(mk_row(4, 4, 4, 4));
    send_row(mk_row(4, 4, 4, 3));
    drain();

    // signed extremes under max
    do_reset();
    bus.conv_pool_mode_i = 1'b0;
    send_row(mk_row(-1, -1, -1, -1));
    send_row(mk_row(-262144, 0, 131071, 1));
    drain();

    // backpressure: R3 stalls while beat0 is held
    do_reset();
    bus.conv_pool_out_rdy_i = 1'b0;
    send_row(mk_row(10, -20, 30, -40));
    send_row(mk_row(-5, 6, 7, -8));
    send_row(mk_row(100, 200, -300, 400));
    drive_row(mk_row(1, 2, 3, 4));
    held = sbq[0].out;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_rdy", 64'(bus.conv_pool_row_rdy_o), 64'd0);
      chk("stall_vld", 64'(bus.conv_pool_out_vld_o), 64'd1);
      chk("stall_hold", 64'(bus.conv_pool_out_o), 64'(held));
    end
    @(posedge clk); #1;
    bus.conv_pool_out_rdy_i = 1'b1;
    wait_accept();
    drain();

    // frame wrap: mode change after row 1 applies only from the next frame
    do_reset();
    bus.conv_pool_mode_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_row(mk_row(int'($urandom_range(0, 524287)) - 262144, int'($urandom_range(0, 524287)) - 262144,
                      int'($urandom_range(0, 524287)) - 262144, int'($urandom_range(0, 524287)) - 262144));
      if (i == 1) bus.conv_pool_mode_i = 1'b1;
    end
    drain();

    // reset mid-frame discards the buffered even row
    bus.conv_pool_mode_i = 1'b0;
    do_reset();
    send_row(mk_row(9000, 9000, 9000, 9000));
    do_reset();
    send_row(mk_row(-9, -8, 3, 2));
    send_row(mk_row(-7, -6, 1, 0));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
